// File: rtl/target_dataslot_arbiter_pkg.sv
// Shared types for the target-dataslot command arbiter: the latched command
// record, completion error codes and the sequencer state encoding.
package target_dataslot_arbiter_pkg;

  // One dataslot command as presented by a requester and as driven to the bridge.
  typedef struct packed {
    logic        write;
    logic [15:0] id;
    logic [31:0] slotoffset;
    logic [31:0] bridgeaddr;
    logic [31:0] length;
  } dataslot_req_t;

  localparam logic [2:0] ERR_OK      = 3'b000;
  localparam logic [2:0] ERR_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    RESPOND   = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/target_dataslot_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo NUM_REQ. Returns both a one-hot grant and its index.
module target_dataslot_arbiter_rr #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/target_dataslot_arbiter.sv
// Shares the bridge target-dataslot command channel between NUM_REQ core-side
// requesters. Round-robin arbitration, parameter latching, edge-triggered
// read/write sequencing with ack timeout, and a one-cycle completion pulse.
//
// Requester handshake: a requester raises req[i] (level) with its parameters
// stable and holds it until it sees req_done[i]. req_grant[i] is high from the
// cycle its parameters are latched until the completion pulse has been issued;
// req_err is valid in the req_done cycle and holds afterwards. Dropping req
// mid-command does not cancel it; a req still high after req_done is a new
// request. Bridge side: read/write are rising-edge triggered, dropped on ack
// (or timeout), and separated by at least two low cycles between commands.
module target_dataslot_arbiter
  import target_dataslot_arbiter_pkg::*;
#(
  parameter int          NUM_REQ     = 2,
  parameter logic [15:0] ACK_TIMEOUT = 16'd65535
) (
  input  logic                      clk_74a,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0][15:0]  req_id,
  input  logic [NUM_REQ-1:0][31:0]  req_slotoffset,
  input  logic [NUM_REQ-1:0][31:0]  req_bridgeaddr,
  input  logic [NUM_REQ-1:0][31:0]  req_length,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [2:0]                req_err,
  output logic                      busy,
  output logic                      target_dataslot_read,
  output logic                      target_dataslot_write,
  input  logic                      target_dataslot_ack,
  input  logic                      target_dataslot_done,
  input  logic [2:0]                target_dataslot_err,
  output logic [15:0]               target_dataslot_id,
  output logic [31:0]               target_dataslot_slotoffset,
  output logic [31:0]               target_dataslot_bridgeaddr,
  output logic [31:0]               target_dataslot_length,
  output state_t                    dbg_state
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [15:0]        ack_cnt_q, ack_cnt_d;
  dataslot_req_t      slot_q, slot_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic [2:0]         err_d;
  logic               busy_d, rd_d, wr_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;

  target_dataslot_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign target_dataslot_id         = slot_q.id;
  assign target_dataslot_slotoffset = slot_q.slotoffset;
  assign target_dataslot_bridgeaddr = slot_q.bridgeaddr;
  assign target_dataslot_length     = slot_q.length;
  assign dbg_state                  = state_q;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    ack_cnt_d   = ack_cnt_q;
    slot_d      = slot_q;
    grant_d     = req_grant;
    done_d      = '0;
    err_d       = req_err;
    rd_d        = target_dataslot_read;
    wr_d        = target_dataslot_write;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_idx_d       = pick_idx;
          grant_d           = pick_grant;
          slot_d.write      = req_write[pick_idx];
          slot_d.id         = req_id[pick_idx];
          slot_d.slotoffset = req_slotoffset[pick_idx];
          slot_d.bridgeaddr = req_bridgeaddr[pick_idx];
          slot_d.length     = req_length[pick_idx];
          rd_d              = ~req_write[pick_idx];
          wr_d              = req_write[pick_idx];
          ack_cnt_d         = '0;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        if (target_dataslot_ack && target_dataslot_done) begin
          // Bridge finished within the ack cycle: skip WAIT_DONE.
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          done_d    = req_grant;
          err_d     = target_dataslot_err;
          ack_cnt_d = '0;
          state_d   = RESPOND;
        end else if (target_dataslot_ack) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          ack_cnt_d = '0;
          state_d   = WAIT_DONE;
        end else if (ack_cnt_q == ACK_TIMEOUT - 16'd1) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          done_d    = req_grant;
          err_d     = ERR_TIMEOUT;
          ack_cnt_d = '0;
          state_d   = RESPOND;
        end else begin
          rd_d      = ~slot_q.write;
          wr_d      = slot_q.write;
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (target_dataslot_done) begin
          done_d  = req_grant;
          err_d   = target_dataslot_err;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        grant_d  = '0;
        rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
        state_d  = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the bridge strobes immediately.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= IDLE;
      rr_ptr_q              <= '0;
      grant_idx_q           <= '0;
      ack_cnt_q             <= '0;
      slot_q                <= '0;
      req_grant             <= '0;
      req_done              <= '0;
      req_err               <= ERR_OK;
      busy                  <= 1'b0;
      target_dataslot_read  <= 1'b0;
      target_dataslot_write <= 1'b0;
    end else begin
      state_q               <= state_d;
      rr_ptr_q              <= rr_ptr_d;
      grant_idx_q           <= grant_idx_d;
      ack_cnt_q             <= ack_cnt_d;
      slot_q                <= slot_d;
      req_grant             <= grant_d;
      req_done              <= done_d;
      req_err               <= err_d;
      busy                  <= busy_d;
      target_dataslot_read  <= rd_d;
      target_dataslot_write <= wr_d;
    end
  end

endmodule

// File: tb/tb_target_dataslot_arbiter.sv
// Directed bench for target_dataslot_arbiter: single read, contention and
// round-robin order, ack timeout, same-cycle ack+done, reset mid-command and
// a requester dropping its request after grant.
module tb_target_dataslot_arbiter;
  import target_dataslot_arbiter_pkg::*;

  localparam int N = 2;

  // Clock and reset
  logic clk_74a = 1'b0;
  logic reset_n;
  always #5 clk_74a = ~clk_74a;

  logic [N-1:0]       req;
  logic [N-1:0]       req_write;
  logic [N-1:0][15:0] req_id;
  logic [N-1:0][31:0] req_slotoffset;
  logic [N-1:0][31:0] req_bridgeaddr;
  logic [N-1:0][31:0] req_length;
  logic [N-1:0]       req_grant;
  logic [N-1:0]       req_done;
  logic [2:0]         req_err;
  logic               busy;
  logic               target_dataslot_read;
  logic               target_dataslot_write;
  logic               target_dataslot_ack;
  logic               target_dataslot_done;
  logic [2:0]         target_dataslot_err;
  logic [15:0]        target_dataslot_id;
  logic [31:0]        target_dataslot_slotoffset;
  logic [31:0]        target_dataslot_bridgeaddr;
  logic [31:0]        target_dataslot_length;
  state_t             dbg_state;

  int checks = 0;
  int errors = 0;
  int hi;
  int pulses;

  target_dataslot_arbiter #(
    .NUM_REQ     (N),
    .ACK_TIMEOUT (16'd8)
  ) dut (
    .clk_74a                    (clk_74a),
    .reset_n                    (reset_n),
    .req                        (req),
    .req_write                  (req_write),
    .req_id                     (req_id),
    .req_slotoffset             (req_slotoffset),
    .req_bridgeaddr             (req_bridgeaddr),
    .req_length                 (req_length),
    .req_grant                  (req_grant),
    .req_done                   (req_done),
    .req_err                    (req_err),
    .busy                       (busy),
    .target_dataslot_read       (target_dataslot_read),
    .target_dataslot_write      (target_dataslot_write),
    .target_dataslot_ack        (target_dataslot_ack),
    .target_dataslot_done       (target_dataslot_done),
    .target_dataslot_err        (target_dataslot_err),
    .target_dataslot_id         (target_dataslot_id),
    .target_dataslot_slotoffset (target_dataslot_slotoffset),
    .target_dataslot_bridgeaddr (target_dataslot_bridgeaddr),
    .target_dataslot_length     (target_dataslot_length),
    .dbg_state                  (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] one;
    one = 1;
    return one << w;
  endfunction

  task automatic do_reset();
    reset_n             = 1'b0;
    target_dataslot_ack  = 1'b0;
    target_dataslot_done = 1'b0;
    target_dataslot_err  = 3'b000;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  // One full command for requester `who`, starting from IDLE with req set.
  // ack_dly: cycles after the strobe rises before ack; done_dly: cycles from
  // ack to done (0 = done together with ack).
  task automatic run_cmd(input int who, input logic exp_wr, input int ack_dly,
                         input int done_dly, input logic [2:0] err);
    int strobe_hi;
    logic [1:0] exp_strobe;
    exp_strobe = exp_wr ? 2'b10 : 2'b01;
    tick();
    chk("grant", 64'(req_grant), 64'(oh(who)));
    chk("strobe_rise", 64'({target_dataslot_write, target_dataslot_read}), 64'(exp_strobe));
    chk("id", 64'(target_dataslot_id), 64'(req_id[who]));
    chk("slotoffset", 64'(target_dataslot_slotoffset), 64'(req_slotoffset[who]));
    chk("bridgeaddr", 64'(target_dataslot_bridgeaddr), 64'(req_bridgeaddr[who]));
    chk("length", 64'(target_dataslot_length), 64'(req_length[who]));
    chk("busy_cmd", 64'(busy), 64'(1));
    strobe_hi = 1;
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      if ({target_dataslot_write, target_dataslot_read} == exp_strobe) strobe_hi++;
    end
    chk("strobe_cycles", 64'(strobe_hi), 64'(ack_dly + 1));
    target_dataslot_ack = 1'b1;
    if (done_dly == 0) begin
      target_dataslot_done = 1'b1;
      target_dataslot_err  = err;
    end
    tick();
    chk("strobe_fall", 64'({target_dataslot_write, target_dataslot_read}), 64'(0));
    if (done_dly != 0) begin
      chk("state_wait", 64'(dbg_state), 64'(WAIT_DONE));
      chk("no_early_done", 64'(req_done), 64'(0));
      for (int k = 0; k < done_dly - 1; k++) tick();
      target_dataslot_done = 1'b1;
      target_dataslot_err  = err;
      tick();
    end
    chk("state_respond", 64'(dbg_state), 64'(RESPOND));
    chk("done_pulse", 64'(req_done), 64'(oh(who)));
    chk("done_err", 64'(req_err), 64'(err));
    target_dataslot_done = 1'b0;
    target_dataslot_ack  = 1'b0;
    target_dataslot_err  = 3'b000;
    req[who]             = 1'b0;
    tick();
    chk("gap_done_low", 64'(req_done), 64'(0));
    chk("gap_grant_low", 64'(req_grant), 64'(0));
    chk("gap_busy", 64'(busy), 64'(1));
    chk("gap_strobe_low", 64'({target_dataslot_write, target_dataslot_read}), 64'(0));
    tick();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_state", 64'(dbg_state), 64'(IDLE));
    chk("idle_strobe_low", 64'({target_dataslot_write, target_dataslot_read}), 64'(0));
    chk("err_hold", 64'(req_err), 64'(err));
  endtask

  initial begin
    reset_n              = 1'b0;
    req                  = '0;
    req_write            = '0;
    req_id               = '0;
    req_slotoffset       = '0;
    req_bridgeaddr       = '0;
    req_length           = '0;
    target_dataslot_ack  = 1'b0;
    target_dataslot_done = 1'b0;
    target_dataslot_err  = 3'b000;

    // Reset state
    repeat (2) tick();
    chk("rst_read", 64'(target_dataslot_read), 64'(0));
    chk("rst_write", 64'(target_dataslot_write), 64'(0));
    chk("rst_grant", 64'(req_grant), 64'(0));
    chk("rst_done", 64'(req_done), 64'(0));
    chk("rst_err", 64'(req_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_id", 64'(target_dataslot_id), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    reset_n = 1'b1;

    // Single read: ack 5 cycles after rise, done 40 cycles after ack
    req_id[0]         = 16'h0003;
    req_slotoffset[0] = 32'h0000_0010;
    req_bridgeaddr[0] = 32'h2000_0000;
    req_length[0]     = 32'h0000_0400;
    req_write[0]      = 1'b0;
    req               = 2'b01;
    run_cmd(0, 1'b0, 5, 40, 3'b000);
    chk("param_hold_id", 64'(target_dataslot_id), 64'(16'h0003));
    chk("param_hold_len", 64'(target_dataslot_length), 64'(32'h400));

    // Contention from reset: 0 first, then 1 (write)
    req_id[1]         = 16'h0007;
    req_slotoffset[1] = 32'h0000_0200;
    req_bridgeaddr[1] = 32'h3000_0000;
    req_length[1]     = 32'h0000_0080;
    req_write         = 2'b10;
    req               = 2'b11;
    do_reset();
    run_cmd(0, 1'b0, 1, 3, 3'b000);
    run_cmd(1, 1'b1, 2, 2, 3'b000);
    // Pointer back at 0: serve 0 alone, then contention serves 1 before 0
    req = 2'b01;
    run_cmd(0, 1'b0, 0, 1, 3'b000);
    req = 2'b11;
    run_cmd(1, 1'b1, 0, 1, 3'b000);
    run_cmd(0, 1'b0, 0, 1, 3'b000);

    // Same-cycle ack and done with err=010
    req = 2'b10;
    run_cmd(1, 1'b1, 1, 0, 3'b010);

    // Ack timeout (ACK_TIMEOUT=8): strobe high 8 cycles, err 111
    req = 2'b01;
    tick();
    chk("to_grant", 64'(req_grant), 64'(2'b01));
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (!target_dataslot_read) break;
      hi++;
      tick();
    end
    chk("to_strobe_cycles", 64'(hi), 64'(8));
    chk("to_done", 64'(req_done), 64'(2'b01));
    chk("to_err", 64'(req_err), 64'(3'b111));
    req = 2'b00;
    tick();
    tick();
    chk("to_idle", 64'(dbg_state), 64'(IDLE));
    chk("to_busy", 64'(busy), 64'(0));

    // Reset during WAIT_DONE (pointer is 1, so requester 1 wins first)
    req = 2'b11;
    tick();
    chk("mr_grant", 64'(req_grant), 64'(2'b10));
    chk("mr_write", 64'(target_dataslot_write), 64'(1));
    target_dataslot_ack = 1'b1;
    tick();
    chk("mr_wait", 64'(dbg_state), 64'(WAIT_DONE));
    #2;
    reset_n             = 1'b0;
    target_dataslot_ack = 1'b0;
    #1;
    chk("mr_read", 64'(target_dataslot_read), 64'(0));
    chk("mr_write0", 64'(target_dataslot_write), 64'(0));
    chk("mr_grant0", 64'(req_grant), 64'(0));
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_state", 64'(dbg_state), 64'(IDLE));
    tick();
    chk("mr_no_done_a", 64'(req_done), 64'(0));
    tick();
    chk("mr_no_done_b", 64'(req_done), 64'(0));
    reset_n = 1'b1;
    run_cmd(0, 1'b0, 0, 1, 3'b000);
    run_cmd(1, 1'b1, 0, 1, 3'b000);

    // Requester 1 drops req right after grant: exactly one done pulse
    req = 2'b10;
    tick();
    chk("drop_grant", 64'(req_grant), 64'(2'b10));
    req                 = 2'b00;
    target_dataslot_ack = 1'b1;
    pulses              = 0;
    tick();
    if (req_done[1]) pulses++;
    chk("drop_wait", 64'(dbg_state), 64'(WAIT_DONE));
    target_dataslot_done = 1'b1;
    tick();
    if (req_done[1]) pulses++;
    target_dataslot_done = 1'b0;
    target_dataslot_ack  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (req_done[1]) pulses++;
    end
    chk("drop_pulses", 64'(pulses), 64'(1));
    chk("drop_busy", 64'(busy), 64'(0));
    chk("drop_grant0", 64'(req_grant), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
